// File: rtl/nv_nvdla_reset_seq.sv
// nv_nvdla_reset_seq: drains the core, pulses its reset and waits for the synchronized
// reset to return before reporting completion; also runs a power-on pulse after nvdla_rst.
module nv_nvdla_reset_seq #(
    parameter int PULSE_CYCLES    = 16,
    parameter int DRAIN_TIMEOUT   = 1024,
    parameter int RELEASE_TIMEOUT = 64
) (
    input  logic nvdla_clk,
    input  logic nvdla_rst,
    input  logic reset_req,
    input  logic quiesce_ack,
    input  logic synced_rstn_fb,
    output logic dla_reset_rstn,
    output logic quiesce_req,
    output logic busy,
    output logic done,
    output logic timeout_err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] DRAIN   = 3'd1;
    localparam logic [2:0] ASSERT  = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] DRAIN_LAST   = 16'(DRAIN_TIMEOUT - 1);
    localparam logic [15:0] RELEASE_LAST = 16'(RELEASE_TIMEOUT - 1);

    logic [2:0]  state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        accept, drain_to, release_to;

    always_comb begin
        accept     = (state == IDLE) && reset_req;
        drain_to   = (state == DRAIN) && !quiesce_ack && (cnt == DRAIN_LAST);
        release_to = (state == RELEASE) && !synced_rstn_fb && (cnt == RELEASE_LAST);
        state_nx   = state;
        case (state)
            IDLE:    state_nx = reset_req ? DRAIN : IDLE;
            DRAIN:   state_nx = (quiesce_ack || drain_to) ? ASSERT : DRAIN;
            ASSERT:  state_nx = (cnt >= PULSE_LAST && !synced_rstn_fb) ? RELEASE : ASSERT;
            RELEASE: state_nx = (synced_rstn_fb || release_to) ? DONE : RELEASE;
            default: state_nx = IDLE;
        endcase
        // the counter restarts on every state entry and sticks at all-ones
        cnt_nx = (state_nx != state) ? 16'd0 : (&cnt ? cnt : cnt + 16'd1);
    end

    always_ff @(posedge nvdla_clk or posedge nvdla_rst) begin
        if (nvdla_rst) begin
            state          <= ASSERT;
            cnt            <= 16'd0;
            dla_reset_rstn <= 1'b0;
            quiesce_req    <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            dla_reset_rstn <= state_nx != ASSERT;
            // a power-on ASSERT never raised quiesce_req, so it only carries over from DRAIN
            quiesce_req    <= (state_nx == DRAIN) || (state_nx == ASSERT && quiesce_req);
            done           <= state_nx == DONE;
            timeout_err    <= accept ? 1'b0 : (timeout_err || drain_to || release_to);
        end
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_nv_nvdla_reset_seq.sv
// tb_nv_nvdla_reset_seq: directed sequences with a two-flop model of the core reset
// synchronizer feeding synced_rstn_fb.
module tb_nv_nvdla_reset_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reset_req = 1'b0;
    logic quiesce_ack = 1'b0;
    logic synced_rstn_fb;
    logic dla_reset_rstn, quiesce_req, busy, done, timeout_err;
    logic s1 = 1'b0, s2 = 1'b0;
    int   fb_mode = 0;
    int   n_tests = 0, n_fail = 0;
    int   low, drain, rel, rel_q, q_low, dones, cyc, timed_out;

    nv_nvdla_reset_seq dut (
        .nvdla_clk(clk),
        .nvdla_rst(rst),
        .reset_req(reset_req),
        .quiesce_ack(quiesce_ack),
        .synced_rstn_fb(synced_rstn_fb),
        .dla_reset_rstn(dla_reset_rstn),
        .quiesce_req(quiesce_req),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= dla_reset_rstn;
        s2 <= s1;
    end
    assign synced_rstn_fb = (fb_mode == 0) ? s2 : (fb_mode == 2);

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req();
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
    endtask

    // Steps the sequence to IDLE while tallying output phases per cycle.
    task automatic run_seq(input int budget, input int ack_at, input int fb_at, input bit spam);
        bit seen_low;
        low = 0; drain = 0; rel = 0; rel_q = 0; q_low = 0; dones = 0; cyc = 0;
        timed_out = 0; seen_low = 0;
        while (busy && cyc < budget) begin
            if (cyc == ack_at) quiesce_ack = 1'b1;
            if (cyc == fb_at) fb_mode = 0;
            reset_req = spam;
            if (!dla_reset_rstn) begin low++; seen_low = 1; end
            if (quiesce_req && !dla_reset_rstn) q_low++;
            if (quiesce_req && dla_reset_rstn && !seen_low) drain++;
            if (quiesce_req && dla_reset_rstn && seen_low) rel_q++;
            if (!quiesce_req && dla_reset_rstn && seen_low && !done) rel++;
            if (done) dones++;
            cyc++;
            tick();
        end
        reset_req = 1'b0;
        quiesce_ack = 1'b0;
        if (busy) timed_out = 1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rstn", dla_reset_rstn, 0);
        chk("rst_qreq", quiesce_req, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_busy", busy, 1);

        rst = 1'b0;
        run_seq(200, -1, -1, 0);
        chk("por_to", timed_out, 0);
        chk("por_low", low, 16);
        chk("por_drain", drain, 0);
        chk("por_qlow", q_low, 0);
        chk("por_rel", rel, 3);
        chk("por_done", dones, 1);
        chk("por_terr", timeout_err, 0);
        chk("por_idle", busy, 0);

        repeat (3) tick();
        start_req();
        chk("norm_qreq", quiesce_req, 1);
        chk("norm_busy", busy, 1);
        run_seq(200, 5, -1, 0);
        chk("norm_to", timed_out, 0);
        chk("norm_drain", drain, 6);
        chk("norm_low", low, 16);
        chk("norm_qlow", q_low, 16);
        chk("norm_relq", rel_q, 0);
        chk("norm_rel", rel, 3);
        chk("norm_done", dones, 1);
        chk("norm_terr", timeout_err, 0);

        start_req();
        run_seq(2000, -1, -1, 0);
        chk("dto_to", timed_out, 0);
        chk("dto_drain", drain, 1024);
        chk("dto_low", low, 16);
        chk("dto_done", dones, 1);
        chk("dto_terr", timeout_err, 1);
        repeat (5) tick();
        chk("dto_terr_hold", timeout_err, 1);

        fb_mode = 1;
        start_req();
        chk("rto_terr_clr", timeout_err, 0);
        run_seq(300, 0, -1, 0);
        chk("rto_to", timed_out, 0);
        chk("rto_drain", drain, 1);
        chk("rto_low", low, 16);
        chk("rto_rel", rel, 64);
        chk("rto_done", dones, 1);
        chk("rto_terr", timeout_err, 1);

        fb_mode = 1;
        start_req();
        run_seq(2000, -1, -1, 0);
        chk("both_drain", drain, 1024);
        chk("both_rel", rel, 64);
        chk("both_terr", timeout_err, 1);

        fb_mode = 2;
        start_req();
        run_seq(300, 0, 31, 0);
        chk("stuck1_to", timed_out, 0);
        chk("stuck1_low", low, 31);
        chk("stuck1_rel", rel, 3);
        chk("stuck1_terr", timeout_err, 0);

        start_req();
        run_seq(300, 0, -1, 1);
        chk("coll_to", timed_out, 0);
        chk("coll_done", dones, 1);
        chk("coll_low", low, 16);
        repeat (4) tick();
        chk("coll_idle", busy, 0);
        chk("coll_nodone", done, 0);

        start_req();
        repeat (10) tick();
        chk("mid_qreq_pre", quiesce_req, 1);
        rst = 1'b1;
        reset_req = 1'b1;
        #1;
        chk("mid_qreq", quiesce_req, 0);
        chk("mid_rstn", dla_reset_rstn, 0);
        chk("mid_busy", busy, 1);
        repeat (3) tick();
        rst = 1'b0;
        reset_req = 1'b0;
        run_seq(200, -1, -1, 0);
        chk("mid_to", timed_out, 0);
        chk("mid_drain", drain, 0);
        chk("mid_qlow", q_low, 0);
        chk("mid_low", low, 16);
        chk("mid_done", dones, 1);
        repeat (3) tick();
        chk("mid_lost_req", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nv_nvdla_reset_seq.md
NV_NVDLA_RESET_SEQ -- requirements
Module: nv_nvdla_reset_seq

Interface
REQ-001 The block SHALL have parameter PULSE_CYCLES, default 16: number of cycles dla_reset_rstn is driven low; legal range 2..65535.
REQ-002 The block SHALL have parameter DRAIN_TIMEOUT, default 1024: maximum DRAIN cycles waiting for quiesce_ack; legal range 2..65535.
REQ-003 The block SHALL have parameter RELEASE_TIMEOUT, default 64: maximum RELEASE cycles waiting for synced_rstn_fb; legal range 2..65535.
REQ-004 Ports SHALL be: nvdla_clk  in  1  sole clock, all logic rising-edge.
REQ-005 nvdla_rst  in  1  reset, asynchronous assert, active-high; one clock, asynchronous active-high reset is fixed.
REQ-006 reset_req  in  1  single-cycle request for a core reset sequence.
REQ-007 quiesce_ack  in  1  core reports outstanding traffic drained; level.
REQ-008 synced_rstn_fb  in  1  synchronized reset from the core reset synchronizer, already in nvdla_clk domain.
REQ-009 dla_reset_rstn  out  1  active-low reset driven to the core reset synchronizer; registered.
REQ-010 quiesce_req  out  1  asks the core to stop issuing and drain; registered level.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 done  out  1  one-cycle pulse at sequence completion.
REQ-013 timeout_err  out  1  sticky flag: a DRAIN or RELEASE timeout occurred in the current or last sequence.

Function
REQ-014 FSM states SHALL be IDLE, DRAIN, ASSERT, RELEASE, DONE; one 16-bit counter cnt, cleared to 0 on every state entry, incremented each cycle otherwise.
REQ-015 IDLE: reset_req=1 at cycle T -> DRAIN at T+1; timeout_err cleared at T+1; quiesce_req=1 from T+1.
REQ-016 reset_req SHALL be ignored in every state other than IDLE, including DONE; no request is queued.
REQ-017 DRAIN: quiesce_ack=1 -> ASSERT next cycle; else cnt==DRAIN_TIMEOUT-1 -> ASSERT next cycle and timeout_err=1.
REQ-018 If quiesce_ack is already high on the first DRAIN cycle, DRAIN SHALL last exactly 1 cycle.
REQ-019 ASSERT: dla_reset_rstn=0 exactly in every ASSERT cycle, 1 in all other states; exit to RELEASE when cnt>=PULSE_CYCLES-1 and synced_rstn_fb==0, else stay.
REQ-020 ASSERT SHALL therefore last exactly PULSE_CYCLES cycles when synced_rstn_fb is low by the last counted cycle, and longer until it is low.
REQ-021 quiesce_req SHALL remain 1 through DRAIN and ASSERT and go 0 on RELEASE entry.
REQ-022 RELEASE: synced_rstn_fb==1 -> DONE next cycle; else cnt==RELEASE_TIMEOUT-1 -> DONE next cycle and timeout_err=1.
REQ-023 DONE SHALL last exactly 1 cycle with done=1, then IDLE.
REQ-024 The counter SHALL saturate, never wrap, at 65535.
REQ-025 timeout_err SHALL hold until the next accepted reset_req; both timeouts in one sequence leave it 1.

Reset
REQ-026 nvdla_rst=1 SHALL immediately force state=ASSERT, cnt=0, dla_reset_rstn=0, quiesce_req=0, done=0, timeout_err=0, busy=1.
REQ-027 After nvdla_rst deasserts, the block SHALL complete a power-on pulse ASSERT->RELEASE->DONE->IDLE, with no DRAIN and quiesce_req staying 0.
REQ-028 nvdla_rst asserted mid-sequence SHALL abort it and restart per REQ-026; a reset_req coincident with nvdla_rst is lost.

Verification
REQ-029 Power-on: release nvdla_rst, fb follows dla_reset_rstn after 2 cycles -> rstn low 16 cycles, done pulse, IDLE, timeout_err=0.
REQ-030 Normal request: reset_req in IDLE, quiesce_ack 5 cycles later -> DRAIN 6 cycles, rstn low 16 cycles, quiesce_req low at RELEASE, single done pulse.
REQ-031 Drain timeout: quiesce_ack held 0 -> ASSERT after exactly 1024 DRAIN cycles, timeout_err=1 until next accepted reset_req.
REQ-032 Release timeout: synced_rstn_fb stuck 0 -> DONE after 64 RELEASE cycles, timeout_err=1; fb stuck 1 in ASSERT -> rstn held low beyond 16 cycles until fb=0.
REQ-033 Collisions: reset_req during busy and on the DONE cycle -> ignored, exactly one done; nvdla_rst pulse mid-DRAIN -> quiesce_req=0, rstn=0 immediately.
